mem_access_unit: RTL and testbench

Parametrised load/store unit between the MEM stage and the data-bus master port. It accepts one access at a time and checks alignment. It then runs a valid/addr_ok/data_ok bus transaction, generates byte strobes and lane-replicated write data, and extracts plus sign/zero-extends load data. The result is returned with address-error flags and the bad virtual address. Optionally, accesses that cross a bus-word boundary are split into two beats instead of trapping.

---
 rtl/mau_pkg.sv | 33 +++
 rtl/mau_lane_align.sv | 72 +++++++
 rtl/mem_access_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings and width helpers for the memory access unit (MAU_SPLIT_EN selects split beats).
// Latency: none, declarations only.
// Backpressure: not applicable.
package mau_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_RESP  = 3'd5,
        ST_EXC   = 3'd6
    } state_t;

    function automatic int mau_bytes(input int dw);
        return dw / 8;
    endfunction

    function automatic int mau_off_w(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Lane placement of store data/strobes and extraction/extension of load data (MAU_SPLIT_EN adds beat 2).
// Latency: purely combinational.
// Backpressure: none, no state.
module mau_lane_align
    import mau_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BYTES  = mau_bytes(DATA_W),
    localparam int OFF_W  = mau_off_w(DATA_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_lo,
`ifdef MAU_SPLIT_EN
    input  logic [DATA_W-1:0] rdata_hi,
    output logic [DATA_W-1:0] wdata_hi,
    output logic [BYTES-1:0]  wstrb_hi,
`endif
    output logic [DATA_W-1:0] wdata_lo,
    output logic [BYTES-1:0]  wstrb_lo,
    output logic [DATA_W-1:0] rdata_ext
);
    localparam int IDX_W = $clog2(DATA_W);

    logic [OFF_W+2:0]  sh;
    logic [BYTES-1:0]  mask;
    logic [DATA_W-1:0] rd_shift;
    logic [IDX_W-1:0]  msb_idx;
    logic              sign;
    int                nb;

    assign sh = {off, 3'b000};

    always_comb begin
        mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            mask[i] = (i < int'(size_bytes(size)));
        end
    end

`ifdef MAU_SPLIT_EN
    logic [2*DATA_W-1:0] wr_wide;
    logic [2*BYTES-1:0]  strb_wide;

    // Bytes pushed past the top lane spill into the second bus word.
    assign wr_wide   = {{DATA_W{1'b0}}, wdata} << sh;
    assign strb_wide = {{BYTES{1'b0}}, mask} << off;
    assign wdata_lo  = wr_wide[DATA_W-1:0];
    assign wdata_hi  = wr_wide[2*DATA_W-1:DATA_W];
    assign wstrb_lo  = strb_wide[BYTES-1:0];
    assign wstrb_hi  = strb_wide[2*BYTES-1:BYTES];
    assign rd_shift  = DATA_W'({rdata_hi, rdata_lo} >> sh);
`else
    assign wdata_lo  = wdata << sh;
    assign wstrb_lo  = mask << off;
    assign rd_shift  = rdata_lo >> sh;
`endif

    always_comb begin
        nb = 8 * int'(size_bytes(size));
        if (nb > DATA_W) nb = DATA_W;
        msb_idx   = IDX_W'(nb - 1);
        sign      = ~uns & rd_shift[msb_idx];
        rdata_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rdata_ext[i] = (i < nb) ? rd_shift[i] : sign;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one access at a time over a valid/addr_ok/data_ok bus; MAU_SPLIT_EN splits word-crossing accesses.
// Latency: resp_valid 2+ cycles after acceptance per beat, 1 cycle for an address trap.
// Backpressure: req_ready only in IDLE; bus_req held until bus_addr_ok.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [ADDR_W-1:0]     req_pc,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_adel,
    output logic                  resp_ades,
    output logic [ADDR_W-1:0]     resp_bad_addr,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata
);
    localparam int BYTES = mau_bytes(DATA_W);
    localparam int OFF_W = mau_off_w(DATA_W);

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [OFF_W-1:0]  off;
        logic [ADDR_W-1:0] pc;
    } acc_t;

    state_t            state_q, state_d;
    acc_t              acc_q, acc_d;
    logic              bus_req_q, bus_req_d, bus_wr_q, bus_wr_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [BYTES-1:0]  bus_wstrb_q, bus_wstrb_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              resp_valid_q, resp_valid_d, resp_adel_q, resp_adel_d, resp_ades_q, resp_ades_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] resp_bad_addr_q, resp_bad_addr_d;

    logic              accept, in_trap, in_size_bad, beat1_done, beat2_done, last1_beat;
    logic [OFF_W-1:0]  in_off, la_off;
    logic [1:0]        la_size;
    logic [DATA_W-1:0] la_rdata_lo, wdata_lo, rdata_ext;
    logic [BYTES-1:0]  wstrb_lo;

    assign accept      = req_valid && (state_q == ST_IDLE);
    assign in_off      = req_addr[OFF_W-1:0];
    assign in_size_bad = (DATA_W == 32) && (req_size == SZ_D);
    assign beat1_done  = ((state_q == ST_REQ1) && bus_addr_ok && bus_data_ok) ||
                         ((state_q == ST_WAIT1) && bus_data_ok);
    assign beat2_done  = ((state_q == ST_REQ2) && bus_addr_ok && bus_data_ok) ||
                         ((state_q == ST_WAIT2) && bus_data_ok);
    // In IDLE the aligner serves the incoming store; afterwards the latched load.
    assign la_off      = (state_q == ST_IDLE) ? in_off : acc_q.off;
    assign la_size     = (state_q == ST_IDLE) ? req_size : acc_q.size;

`ifdef MAU_SPLIT_EN
    logic              split_q, split_d, in_cross;
    logic [DATA_W-1:0] wdata2_q, wdata2_d, rdata1_q, rdata1_d, wdata_hi;
    logic [BYTES-1:0]  wstrb2_q, wstrb2_d, wstrb_hi;

    assign in_trap     = in_size_bad;
    assign in_cross    = (int'(in_off) + int'(size_bytes(req_size))) > BYTES;
    assign last1_beat  = !split_q;
    assign la_rdata_lo = ((state_q == ST_REQ2) || (state_q == ST_WAIT2)) ? rdata1_q : bus_rdata;
`else
    assign in_trap     = in_size_bad || (|(in_off & OFF_W'(size_bytes(req_size) - 4'd1)));
    assign last1_beat  = 1'b1;
    assign la_rdata_lo = bus_rdata;
`endif

    mau_lane_align #(.DATA_W(DATA_W)) u_align (
        .off       (la_off),
        .size      (la_size),
        .uns       (acc_q.uns),
        .wdata     (req_wdata),
        .rdata_lo  (la_rdata_lo),
`ifdef MAU_SPLIT_EN
        .rdata_hi  (bus_rdata),
        .wdata_hi  (wdata_hi),
        .wstrb_hi  (wstrb_hi),
`endif
        .wdata_lo  (wdata_lo),
        .wstrb_lo  (wstrb_lo),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = in_trap ? ST_EXC : ST_REQ1;
            ST_REQ1:  if (bus_addr_ok) state_d = !bus_data_ok ? ST_WAIT1 :
                                                 (last1_beat ? ST_RESP : ST_REQ2);
            ST_WAIT1: if (bus_data_ok) state_d = last1_beat ? ST_RESP : ST_REQ2;
`ifdef MAU_SPLIT_EN
            ST_REQ2:  if (bus_addr_ok) state_d = bus_data_ok ? ST_RESP : ST_WAIT2;
            ST_WAIT2: if (bus_data_ok) state_d = ST_RESP;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == ST_IDLE);
        acc_d           = acc_q;
        bus_req_d       = (state_d == ST_REQ1) || (state_d == ST_REQ2);
        bus_wr_d        = bus_wr_q;
        bus_addr_d      = bus_addr_q;
        bus_wstrb_d     = bus_wstrb_q;
        bus_wdata_d     = bus_wdata_q;
        resp_valid_d    = (state_d == ST_RESP) || (state_d == ST_EXC);
        resp_rdata_d    = resp_rdata_q;
        resp_adel_d     = resp_adel_q;
        resp_ades_d     = resp_ades_q;
        resp_bad_addr_d = resp_bad_addr_q;
`ifdef MAU_SPLIT_EN
        split_d         = split_q;
        wdata2_d        = wdata2_q;
        wstrb2_d        = wstrb2_q;
        rdata1_d        = rdata1_q;
`endif
        if (accept) begin
            acc_d       = '{we: req_we, size: req_size, uns: req_unsigned, off: in_off, pc: req_pc};
            bus_wr_d    = req_we;
            bus_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wstrb_d = req_we ? wstrb_lo : '0;
            bus_wdata_d = wdata_lo;
`ifdef MAU_SPLIT_EN
            split_d     = in_cross;
            wdata2_d    = wdata_hi;
            wstrb2_d    = req_we ? wstrb_hi : '0;
`endif
            if (in_trap) begin
                resp_rdata_d    = '0;
                resp_adel_d     = !req_we;
                resp_ades_d     = req_we;
                resp_bad_addr_d = req_addr;
            end
        end
`ifdef MAU_SPLIT_EN
        if (beat1_done && split_q) begin
            rdata1_d    = bus_rdata;
            bus_addr_d  = bus_addr_q + ADDR_W'(BYTES);
            bus_wstrb_d = wstrb2_q;
            bus_wdata_d = wdata2_q;
        end
`endif
        if (state_d == ST_RESP) begin
            resp_rdata_d    = acc_q.we ? '0 : rdata_ext;
            resp_adel_d     = 1'b0;
            resp_ades_d     = 1'b0;
            resp_bad_addr_d = acc_q.pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q           <= '0;
            bus_req_q       <= 1'b0;
            bus_wr_q        <= 1'b0;
            bus_addr_q      <= '0;
            bus_wstrb_q     <= '0;
            bus_wdata_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_adel_q     <= 1'b0;
            resp_ades_q     <= 1'b0;
            resp_bad_addr_q <= '0;
        end else begin
            acc_q           <= acc_d;
            bus_req_q       <= bus_req_d;
            bus_wr_q        <= bus_wr_d;
            bus_addr_q      <= bus_addr_d;
            bus_wstrb_q     <= bus_wstrb_d;
            bus_wdata_q     <= bus_wdata_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_adel_q     <= resp_adel_d;
            resp_ades_q     <= resp_ades_d;
            resp_bad_addr_q <= resp_bad_addr_d;
        end
    end

`ifdef MAU_SPLIT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            split_q  <= 1'b0;
            wdata2_q <= '0;
            wstrb2_q <= '0;
            rdata1_q <= '0;
        end else begin
            split_q  <= split_d;
            wdata2_q <= wdata2_d;
            wstrb2_q <= wstrb2_d;
            rdata1_q <= rdata1_d;
        end
    end
`endif

    assign bus_req       = bus_req_q;
    assign bus_wr        = bus_wr_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wstrb     = bus_wstrb_q;
    assign bus_wdata     = bus_wdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_adel     = resp_adel_q;
    assign resp_ades     = resp_ades_q;
    assign resp_bad_addr = resp_bad_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32-bit instance with a scripted bus responder, plus a 64-bit instance.
// Expectations depend on MAU_SPLIT_EN for misaligned accesses.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, req_pc = 0;
    logic        req_ready, resp_valid, resp_adel, resp_ades;
    logic [31:0] resp_rdata, resp_bad_addr;
    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok = 0, bus_data_ok = 0;
    logic [31:0] bus_rdata = 0;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_adel(resp_adel),
        .resp_ades(resp_ades), .resp_bad_addr(resp_bad_addr),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    logic        d_req_valid = 0, d_req_we = 0, d_req_unsigned = 0;
    logic [1:0]  d_req_size = 0;
    logic [31:0] d_req_addr = 0, d_req_pc = 0;
    logic [63:0] d_req_wdata = 0;
    logic        d_req_ready, d_resp_valid, d_resp_adel, d_resp_ades;
    logic [63:0] d_resp_rdata, d_bus_wdata;
    logic [31:0] d_resp_bad_addr, d_bus_addr;
    logic        d_bus_req, d_bus_wr;
    logic [7:0]  d_bus_wstrb;
    logic        d_bus_addr_ok = 0, d_bus_data_ok = 0;
    logic [63:0] d_bus_rdata = 0;

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we), .req_size(d_req_size),
        .req_unsigned(d_req_unsigned), .req_addr(d_req_addr), .req_wdata(d_req_wdata), .req_pc(d_req_pc),
        .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_adel(d_resp_adel),
        .resp_ades(d_resp_ades), .resp_bad_addr(d_resp_bad_addr),
        .bus_req(d_bus_req), .bus_wr(d_bus_wr), .bus_addr(d_bus_addr), .bus_wstrb(d_bus_wstrb),
        .bus_wdata(d_bus_wdata), .bus_addr_ok(d_bus_addr_ok), .bus_data_ok(d_bus_data_ok),
        .bus_rdata(d_bus_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] mem [logic [31:0]];

    int          r_lat, nbeats;
    logic        got, saw_req, r_adel, r_ades;
    logic [31:0] r_rdata, r_bad;
    logic [31:0] b_addr [0:1];
    logic [3:0]  b_strb [0:1];
    logic [31:0] b_wd   [0:1];
    logic        b_wr   [0:1];

    // Presents one access, then plays the bus slave with aw idle request cycles
    // before addr_ok and dw cycles from addr_ok to data_ok (0 = same cycle).
    task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] pc, input int aw, input int dw);
        int cyc, cnt, ph;
        logic [31:0] wa;
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_pc = pc;
        @(posedge clk);
        #1 req_valid = 0;
        got = 0; saw_req = 0; nbeats = 0; cyc = 0; cnt = 0; ph = 0; r_lat = -1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus_addr_ok = 0; bus_data_ok = 0;
            if (resp_valid) begin
                got = 1; r_lat = cyc; r_rdata = resp_rdata;
                r_adel = resp_adel; r_ades = resp_ades; r_bad = resp_bad_addr;
            end
            saw_req = saw_req | bus_req;
            if (ph == 0 && bus_req) begin
                if (cnt == aw) begin
                    bus_addr_ok = 1;
                    if (nbeats < 2) begin
                        b_addr[nbeats] = bus_addr; b_strb[nbeats] = bus_wstrb;
                        b_wd[nbeats] = bus_wdata; b_wr[nbeats] = bus_wr;
                    end
                    nbeats++;
                    wa = bus_addr;
                    cnt = 0; ph = 1;
                    if (dw == 0) begin
                        bus_data_ok = 1; bus_rdata = mem.exists(wa) ? mem[wa] : 32'h0; ph = 0;
                    end
                end else cnt++;
            end else if (ph == 1) begin
                cnt++;
                if (cnt == dw) begin
                    bus_data_ok = 1; bus_rdata = mem.exists(wa) ? mem[wa] : 32'h0;
                    ph = 0; cnt = 0;
                end
            end
        end
        bus_addr_ok = 0; bus_data_ok = 0;
        n_chk++;
        if (!got) $display("FAIL timeout: no resp_valid within %0d cycles for addr %h", cyc, addr);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
        n_chk++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req: got %b want 0", bus_req); else n_pass++;
        n_chk++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_chk++; if (resp_bad_addr !== 32'h0) $display("FAIL rst_bad_addr: got %h want 0", resp_bad_addr); else n_pass++;
        n_chk++; if (bus_wstrb !== 4'h0) $display("FAIL rst_wstrb: got %b want 0000", bus_wstrb); else n_pass++;
        n_chk++; if (d_req_ready !== 1'b1) $display("FAIL rst_ready64: got %b want 1", d_req_ready); else n_pass++;
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_lw();
        mem[32'h100] = 32'h8899AABB;
        run_access(0, SZ_W, 0, 32'h100, 0, 32'h400, 0, 1);
        n_chk++; if (r_lat !== 3) $display("FAIL lw_latency: got %0d want 3", r_lat); else n_pass++;
        n_chk++; if (r_rdata !== 32'h8899AABB) $display("FAIL lw_rdata: got %h want 8899aabb", r_rdata); else n_pass++;
        n_chk++; if (b_addr[0] !== 32'h100 || b_strb[0] !== 4'b0000 || b_wr[0] !== 1'b0)
            $display("FAIL lw_bus: addr %h strb %b wr %b want 100 0000 0", b_addr[0], b_strb[0], b_wr[0]); else n_pass++;
        n_chk++; if (nbeats !== 1 || r_adel !== 1'b0 || r_bad !== 32'h400)
            $display("FAIL lw_resp: beats %0d adel %b bad %h want 1 0 400", nbeats, r_adel, r_bad); else n_pass++;
    endtask

    task automatic test_lb_sign();
        mem[32'h100] = 32'h80112233;
        run_access(0, SZ_B, 0, 32'h103, 0, 32'h404, 1, 1);
        n_chk++; if (r_rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata: got %h want ffffff80", r_rdata); else n_pass++;
        n_chk++; if (r_lat !== 4 || b_addr[0] !== 32'h100)
            $display("FAIL lb_timing: lat %0d addr %h want 4 100", r_lat, b_addr[0]); else n_pass++;
        run_access(0, SZ_B, 1, 32'h103, 0, 32'h408, 0, 1);
        n_chk++; if (r_rdata !== 32'h00000080) $display("FAIL lbu_rdata: got %h want 00000080", r_rdata); else n_pass++;
    endtask

    task automatic test_sh();
        run_access(1, SZ_H, 0, 32'h102, 32'h00001234, 32'h40C, 0, 0);
        n_chk++; if (b_strb[0] !== 4'b1100 || b_wd[0][31:16] !== 16'h1234 || b_wr[0] !== 1'b1)
            $display("FAIL sh_bus: strb %b wdata %h wr %b want 1100 1234xxxx 1", b_strb[0], b_wd[0], b_wr[0]); else n_pass++;
        n_chk++; if (r_lat !== 2) $display("FAIL sh_latency: got %0d want 2", r_lat); else n_pass++;
        n_chk++; if (r_rdata !== 32'h0 || r_ades !== 1'b0 || r_bad !== 32'h40C)
            $display("FAIL sh_resp: rdata %h ades %b bad %h want 0 0 40c", r_rdata, r_ades, r_bad); else n_pass++;
    endtask

    task automatic test_size3_trap();
        run_access(0, SZ_D, 0, 32'h100, 0, 32'h410, 0, 1);
        n_chk++; if (r_lat !== 1 || saw_req !== 1'b0)
            $display("FAIL ld32_trap: lat %0d bus_req_seen %b want 1 0", r_lat, saw_req); else n_pass++;
        n_chk++; if (r_adel !== 1'b1 || r_ades !== 1'b0 || r_bad !== 32'h100 || r_rdata !== 32'h0)
            $display("FAIL ld32_flags: adel %b ades %b bad %h rdata %h want 1 0 100 0", r_adel, r_ades, r_bad, r_rdata); else n_pass++;
    endtask

`ifdef MAU_SPLIT_EN
    task automatic test_split();
        mem[32'h100] = 32'hAAAA5566;
        mem[32'h104] = 32'h1122BBBB;
        run_access(0, SZ_W, 0, 32'h102, 0, 32'h420, 0, 1);
        n_chk++; if (nbeats !== 2 || b_addr[0] !== 32'h100 || b_addr[1] !== 32'h104)
            $display("FAIL split_lw_beats: n %0d a0 %h a1 %h want 2 100 104", nbeats, b_addr[0], b_addr[1]); else n_pass++;
        n_chk++; if (r_rdata !== 32'hBBBBAAAA || r_adel !== 1'b0 || r_lat !== 5)
            $display("FAIL split_lw_resp: rdata %h adel %b lat %0d want bbbbaaaa 0 5", r_rdata, r_adel, r_lat); else n_pass++;
        run_access(1, SZ_W, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h424, 0, 1);
        n_chk++; if (b_addr[0] !== 32'hFFFFFFFC || b_strb[0] !== 4'b1100 || b_wd[0][31:16] !== 16'hF00D)
            $display("FAIL split_sw_b1: a %h s %b d %h want fffffffc 1100 f00dxxxx", b_addr[0], b_strb[0], b_wd[0]); else n_pass++;
        n_chk++; if (b_addr[1] !== 32'h0 || b_strb[1] !== 4'b0011 || b_wd[1][15:0] !== 16'hCAFE || r_ades !== 1'b0)
            $display("FAIL split_sw_b2: a %h s %b d %h ades %b want 0 0011 xxxxcafe 0", b_addr[1], b_strb[1], b_wd[1], r_ades); else n_pass++;
        mem[32'h100] = 32'h12C0DE34;
        run_access(0, SZ_H, 0, 32'h101, 0, 32'h428, 0, 1);
        n_chk++; if (nbeats !== 1 || r_rdata !== 32'hFFFFC0DE)
            $display("FAIL split_lh_inword: n %0d rdata %h want 1 ffffc0de", nbeats, r_rdata); else n_pass++;
    endtask
`else
    task automatic test_misaligned_trap();
        run_access(1, SZ_W, 0, 32'h101, 32'h55, 32'h430, 0, 1);
        n_chk++; if (saw_req !== 1'b0 || r_lat !== 1)
            $display("FAIL sw_mis_nobus: bus_req_seen %b lat %0d want 0 1", saw_req, r_lat); else n_pass++;
        n_chk++; if (r_ades !== 1'b1 || r_adel !== 1'b0 || r_bad !== 32'h101)
            $display("FAIL sw_mis_flags: ades %b adel %b bad %h want 1 0 101", r_ades, r_adel, r_bad); else n_pass++;
        run_access(0, SZ_H, 0, 32'h103, 0, 32'h434, 0, 1);
        n_chk++; if (r_adel !== 1'b1 || r_ades !== 1'b0 || r_bad !== 32'h103 || saw_req !== 1'b0)
            $display("FAIL lh_mis_flags: adel %b ades %b bad %h req %b want 1 0 103 0", r_adel, r_ades, r_bad, saw_req); else n_pass++;
    endtask
`endif

    task automatic test_back_to_back();
        mem[32'h200] = 32'h80017FFF;
        run_access(0, SZ_H, 0, 32'h202, 0, 32'h440, 2, 2);
        n_chk++; if (r_rdata !== 32'hFFFF8001 || r_lat !== 6)
            $display("FAIL b2b_lh: rdata %h lat %0d want ffff8001 6", r_rdata, r_lat); else n_pass++;
        run_access(0, SZ_H, 1, 32'h200, 0, 32'h444, 2, 2);
        n_chk++; if (r_rdata !== 32'h00007FFF || r_lat !== 6)
            $display("FAIL b2b_lhu: rdata %h lat %0d want 00007fff 6", r_rdata, r_lat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic bad_resp;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = SZ_W; req_addr = 32'h100; req_pc = 32'h450;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk); bus_addr_ok = 1;
        @(negedge clk); bus_addr_ok = 0;
        resetn = 0;
        #1;
        n_chk++; if (bus_req !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL midrst_now: bus_req %b ready %b want 0 1", bus_req, req_ready); else n_pass++;
        bad_resp = 0;
        bus_data_ok = 1;
        repeat (3) begin
            @(negedge clk);
            bad_resp = bad_resp | resp_valid;
        end
        bus_data_ok = 0;
        resetn = 1;
        repeat (3) begin
            @(negedge clk);
            bad_resp = bad_resp | resp_valid | bus_req;
        end
        n_chk++; if (bad_resp !== 1'b0) $display("FAIL midrst_noresp: stray resp/bus_req %b want 0", bad_resp); else n_pass++;
    endtask

    task automatic test_dw64();
        @(negedge clk);
        d_req_valid = 1; d_req_we = 0; d_req_size = SZ_D; d_req_addr = 32'h8; d_req_pc = 32'h460;
        @(posedge clk);
        #1 d_req_valid = 0;
        @(negedge clk);
        n_chk++; if (d_bus_req !== 1'b1 || d_bus_addr !== 32'h8 || d_bus_wstrb !== 8'h00)
            $display("FAIL ld64_bus: req %b addr %h strb %h want 1 8 00", d_bus_req, d_bus_addr, d_bus_wstrb); else n_pass++;
        d_bus_addr_ok = 1;
        @(negedge clk);
        d_bus_addr_ok = 0; d_bus_data_ok = 1; d_bus_rdata = 64'hFEDCBA9876543210;
        @(negedge clk);
        d_bus_data_ok = 0;
        n_chk++; if (d_resp_valid !== 1'b1 || d_resp_rdata !== 64'hFEDCBA9876543210 || d_resp_adel !== 1'b0)
            $display("FAIL ld64_resp: v %b rdata %h adel %b want 1 fedcba9876543210 0", d_resp_valid, d_resp_rdata, d_resp_adel); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_sign();
        test_sh();
        test_size3_trap();
`ifdef MAU_SPLIT_EN
        test_split();
`else
        test_misaligned_trap();
`endif
        test_back_to_back();
        test_dw64();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
